// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment PWM display back-end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seg7_pkg;

    localparam int SEG_W = 7;
    localparam int PWM_W = 4;

    // Display FSM states; BLINK_OFF is only reachable when blinking is built in.
    typedef enum logic [1:0] {
        BLANK     = 2'd0,
        SHOW      = 2'd1,
        BLINK_OFF = 2'd2
    } state_e;

    // Common-cathode glyphs, bit order {g,f,e,d,c,b,a}, active-high.
    localparam logic [SEG_W-1:0] GLYPH_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_pwm_driver_hex_glyph_rom.sv
// Hex digit to 7-segment glyph lookup.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
module hex_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0]       digit_i,
    output logic [SEG_W-1:0] glyph_o
);

    assign glyph_o = GLYPH_TBL[digit_i];

endmodule

// File: rtl/seg7_pwm_driver.sv
// Single-digit 7-segment driver: holds a strobed hex value, PWM dimming, DP update flash, optional blink (SEG7_BLINK_EN).
// Latency: strobe at edge E updates held state at E; seg_o/dp_o show it after E+1.
// Backpressure: none; every strobe is accepted, brightness/blink are sampled each cycle.
module seg7_pwm_driver
    import seg7_pkg::*;
#(
    parameter int DP_HOLD   = 1_000_000,
    parameter int BLINK_DIV = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       digit_i,
    input  logic             digit_valid_i,
    input  logic [PWM_W-1:0] brightness_i,
    input  logic             blink_req_i,
    output logic [SEG_W-1:0] seg_o,
    output logic             dp_o
);

    localparam int DP_W = 24;

    state_e             state_q, state_d;
    logic [3:0]         digit_q;
    logic [PWM_W-1:0]   pwm_cnt_q;
    logic [DP_W-1:0]    dp_cnt_q;
    logic [SEG_W-1:0]   seg_q;
    logic               dp_q;
    logic [SEG_W-1:0]   glyph;
    logic               pwm_on;
    logic               dp_raw;
    logic               lit;

    hex_glyph_rom u_rom (
        .digit_i (digit_q),
        .glyph_o (glyph)
    );

    assign pwm_on = (brightness_i == {PWM_W{1'b1}}) || (pwm_cnt_q < brightness_i);
    assign dp_raw = (dp_cnt_q != '0);
    assign lit    = (state_q == SHOW) && pwm_on;

`ifdef SEG7_BLINK_EN
    logic [BLINK_DIV-1:0] blink_cnt_q;
    logic                 blink_wrap;

    assign blink_wrap = blink_req_i && (blink_cnt_q == {BLINK_DIV{1'b1}});

    // Blink timebase: free-runs while blinking is requested, parked at zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
        end else if (blink_req_i) begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end else begin
            blink_cnt_q <= '0;
        end
    end

    // Next-state: leave BLANK on the first strobe, toggle SHOW/BLINK_OFF on each wrap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK: begin
                if (digit_valid_i) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (blink_wrap) begin
                    state_d = BLINK_OFF;
                end
            end
            BLINK_OFF: begin
                if (!blink_req_i || blink_wrap) begin
                    state_d = SHOW;
                end
            end
            default: state_d = BLANK;
        endcase
    end
`else
    logic unused_blink_req;
    assign unused_blink_req = blink_req_i;

    // Next-state: leave BLANK on the first strobe and stay in SHOW thereafter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK: begin
                if (digit_valid_i) begin
                    state_d = SHOW;
                end
            end
            SHOW:    state_d = SHOW;
            default: state_d = BLANK;
        endcase
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the digit on each strobe; it is held until the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q <= 4'h0;
        end else if (digit_valid_i) begin
            digit_q <= digit_i;
        end
    end

    // Free-running PWM phase counter, wraps 15 -> 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    // DP flash timer: reloaded by every strobe, counts down and sticks at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dp_cnt_q <= '0;
        end else if (digit_valid_i) begin
            dp_cnt_q <= DP_W'(DP_HOLD);
        end else if (dp_raw) begin
            dp_cnt_q <= dp_cnt_q - 1'b1;
        end
    end

    // Registered pin drive so segments change only on clock edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= '0;
            dp_q  <= 1'b0;
        end else begin
            seg_q <= lit ? glyph : '0;
            dp_q  <= lit && dp_raw;
        end
    end

    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule

// File: tb/tb_seg7_pwm_driver.sv
// Self-checking bench for seg7_pwm_driver with DP_HOLD=8, BLINK_DIV=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_pwm_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] digit_i;
    logic       digit_valid_i;
    logic [3:0] brightness_i;
    logic       blink_req_i;
    logic [6:0] seg_o;
    logic       dp_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] digit;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs [16];

    seg7_pwm_driver #(
        .DP_HOLD   (8),
        .BLINK_DIV (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .digit_i       (digit_i),
        .digit_valid_i (digit_valid_i),
        .brightness_i  (brightness_i),
        .blink_req_i   (blink_req_i),
        .seg_o         (seg_o),
        .dp_o          (dp_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] d);
        digit_i       = d;
        digit_valid_i = 1'b1;
        tick();
        digit_valid_i = 1'b0;
    endtask

    initial begin
        int lit_cnt;
        int dark_cnt;
        int bad_cnt;
        int rises;
        logic prev_dp;

        vecs[0]  = '{4'h0, 7'h3F}; vecs[1]  = '{4'h1, 7'h06};
        vecs[2]  = '{4'h2, 7'h5B}; vecs[3]  = '{4'h3, 7'h4F};
        vecs[4]  = '{4'h4, 7'h66}; vecs[5]  = '{4'h5, 7'h6D};
        vecs[6]  = '{4'h6, 7'h7D}; vecs[7]  = '{4'h7, 7'h07};
        vecs[8]  = '{4'h8, 7'h7F}; vecs[9]  = '{4'h9, 7'h6F};
        vecs[10] = '{4'hA, 7'h77}; vecs[11] = '{4'hB, 7'h7C};
        vecs[12] = '{4'hC, 7'h39}; vecs[13] = '{4'hD, 7'h5E};
        vecs[14] = '{4'hE, 7'h79}; vecs[15] = '{4'hF, 7'h71};

        rst_n         = 1'b0;
        digit_i       = 4'h9;
        digit_valid_i = 1'b0;
        brightness_i  = 4'hF;
        blink_req_i   = 1'b0;
        repeat (3) tick();
        chk("reset_seg", int'(seg_o), 0);
        chk("reset_dp", int'(dp_o), 0);
        rst_n = 1'b1;

        // Dark for 100 cycles with no strobe, regardless of digit_i.
        bad_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (seg_o != 7'h00 || dp_o != 1'b0) bad_cnt++;
        end
        chk("blank_no_strobe_bad_cycles", bad_cnt, 0);

        // Glyph table, full brightness: each strobe appears one edge later with DP lit.
        for (int i = 0; i < 16; i++) begin
            strobe(vecs[i].digit);
            tick();
            chk($sformatf("glyph_%0h_seg", vecs[i].digit), int'(seg_o), int'(vecs[i].seg));
            chk($sformatf("glyph_%0h_dp", vecs[i].digit), int'(dp_o), 1);
        end

        // DP flash lasts exactly DP_HOLD cycles.
        repeat (20) tick();
        chk("dp_idle_before_flash", int'(dp_o), 0);
        strobe(4'h6);
        lit_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) chk("digit6_seg", int'(seg_o), 'h7D);
            if (k == 15) chk("digit6_seg_late", int'(seg_o), 'h7D);
            if (dp_o) lit_cnt++;
        end
        chk("dp_hold_cycles", lit_cnt, 8);

        // PWM duty: brightness 4 -> 4 of 16, brightness 0 -> none.
        strobe(4'h1);
        brightness_i = 4'h4;
        tick();
        lit_cnt = 0; dark_cnt = 0; bad_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (seg_o == 7'h06) lit_cnt++;
            else if (seg_o == 7'h00) dark_cnt++;
            else bad_cnt++;
        end
        chk("pwm4_lit", lit_cnt, 4);
        chk("pwm4_dark", dark_cnt, 12);
        chk("pwm4_bad", bad_cnt, 0);
        brightness_i = 4'h0;
        tick();
        lit_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (seg_o != 7'h00 || dp_o) lit_cnt++;
        end
        chk("pwm0_lit", lit_cnt, 0);
        brightness_i = 4'hF;
        tick();
        chk("pwmF_seg", int'(seg_o), 'h06);

        // Back-to-back strobes 5 cycles apart: DP restarts and stays solid 13 cycles.
        repeat (20) tick();
        strobe(4'h2);
        lit_cnt = 0; rises = 0; prev_dp = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (k == 5) begin
                digit_i = 4'h3;
                digit_valid_i = 1'b1;
            end
            tick();
            digit_valid_i = 1'b0;
            if (k == 1) chk("seq_seg_2", int'(seg_o), 'h5B);
            if (k == 6) chk("seq_seg_3", int'(seg_o), 'h4F);
            if (dp_o) lit_cnt++;
            if (dp_o && !prev_dp) rises++;
            prev_dp = dp_o;
        end
        chk("seq_dp_cycles", lit_cnt, 13);
        chk("seq_dp_rises", rises, 1);

`ifdef SEG7_BLINK_EN
        // Blink: 8 lit / 8 dark, starting dark on the 9th edge after the request.
        bad_cnt = 0;
        blink_req_i = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            tick();
            if (((k - 1) / 8) % 2 == 0) begin
                if (seg_o != 7'h4F) bad_cnt++;
            end else begin
                if (seg_o != 7'h00) bad_cnt++;
            end
        end
        chk("blink_pattern_bad", bad_cnt, 0);
        blink_req_i = 1'b0;
        tick();
        chk("blink_drop_edge1", int'(seg_o), 0);
        tick();
        chk("blink_drop_edge2", int'(seg_o), 'h4F);

        // Strobe inside a dark half keeps it dark, then reset mid flash/dark.
        blink_req_i = 1'b1;
        repeat (10) tick();
        chk("blink_dark_before_strobe", int'(seg_o), 0);
        strobe(4'h5);
        tick();
        chk("strobe_in_dark_seg", int'(seg_o), 0);
`else
        strobe(4'h5);
        tick();
        chk("flash_before_reset_dp", int'(dp_o), 1);
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        blink_req_i = 1'b0;
        chk("midrst_seg", int'(seg_o), 0);
        chk("midrst_dp", int'(dp_o), 0);
        bad_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (seg_o != 7'h00 || dp_o) bad_cnt++;
        end
        chk("post_reset_blank_bad", bad_cnt, 0);
        strobe(4'hA);
        chk("post_reset_strobe_edge", int'(seg_o), 0);
        tick();
        chk("post_reset_glyph", int'(seg_o), 'h77);
        chk("post_reset_dp", int'(dp_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_pwm_driver.md
# seg7_pwm_driver

Display back-end for the digit counter: accepts a 4-bit value with a one-cycle valid strobe, holds it, and drives a single common-cathode 7-segment digit plus decimal point. Adds PWM brightness control, a decimal-point "update" flash on every new value, and optional blinking. Sits directly downstream of the counter stage, between `display_value` and `uo_out[7:0]`.

## Interface
- `DP_HOLD`, 1_000_000: cycles `dp_o` stays lit after each accepted value; legal range 1..2^24-1.
- `BLINK_DIV`, 23: blink half-period is 2^BLINK_DIV cycles; legal range 2..24.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `digit_i` in 4: value to display, 0x0..0xF.
- `digit_valid_i` in 1: single-cycle strobe; `digit_i` is sampled when high.
- `brightness_i` in 4: duty level; 0 = dark, 0xF = fully on.
- `blink_req_i` in 1: level; request blinking.
- `seg_o` out 7: segments {g,f,e,d,c,b,a}, active-high, registered.
- `dp_o` out 1: decimal point, active-high, registered.

## Operation
- Reset: `seg_o`=0, `dp_o`=0, held digit=0, PWM counter=0, DP counter=0, blink counter=0, state BLANK.
- FSM states: BLANK, SHOW, BLINK_OFF.
  - BLANK -> SHOW on first `digit_valid_i`; the display is dark until then.
  - SHOW -> BLINK_OFF when `blink_req_i`=1 and the blink counter wraps.
  - BLINK_OFF -> SHOW on the next blink counter wrap, or on the first cycle `blink_req_i`=0.
  - A valid strobe in BLINK_OFF updates the held digit and leaves the state unchanged.
- Glyph decode (hex, {g..a}): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- PWM: a free-running 4-bit counter increments every cycle and wraps 15->0. Output enable `pwm_on` = (`brightness_i`==0xF) or (`pwm_cnt` < `brightness_i`). Brightness 0 gives no lit cycles; 0xF gives 16/16.
- DP flash: each accepted strobe loads the DP counter with `DP_HOLD`. The counter decrements to 0 and saturates there. `dp_raw` = counter != 0. A strobe during an active flash reloads the counter, which restarts the flash.
- Output register each cycle:
  - `seg_o` = (state==SHOW && `pwm_on`) ? glyph(held digit) : 0.
  - `dp_o` = (state==SHOW && `pwm_on` && `dp_raw`).
- Blink counter: BLINK_DIV bits wide. It runs only while `blink_req_i`=1 and clears to 0 when `blink_req_i`=0.
- `brightness_i` and `blink_req_i` are sampled every cycle with no handshake. `digit_i` is ignored when there is no strobe.
- Reset asserted mid-operation returns every register to its reset value on that edge, regardless of state.

## Timing
- Strobe sampled at edge E: the held digit and DP counter update at E. `seg_o` and `dp_o` reflect the new value at E+1, so latency is 2 edges from strobe to pin.
- With `brightness_i`=0xF and no blink, the lit interval of `dp_o` is exactly `DP_HOLD` cycles.
- Brightness change takes effect on the next output register edge, with no glitch beyond one cycle.
- Blink: after `blink_req_i` rises, the first dark half begins 2^BLINK_DIV cycles later plus 1 register cycle.

## Configuration
- `SEG7_BLINK_EN` defined: the blink counter and BLINK_OFF state are implemented as described.
- `SEG7_BLINK_EN` undefined:
  - No blink counter and no BLINK_OFF state are present.
  - `blink_req_i` is ignored, and it is tied into the unused-signal sink.
  - The FSM has only BLANK and SHOW.

## Structure
- Package `seg7_pkg` holds:
  - the state enum (BLANK, SHOW, BLINK_OFF);
  - the 16-entry glyph constant table;
  - segment width 7 and PWM width 4.
- One combinational sub-module, `hex_glyph_rom`: 4-bit digit in, 7-bit glyph out, from the `seg7_pkg` table. Everything else lives in `seg7_pwm_driver`.

## Test plan
- Reset released with no strobe for 100 cycles -> `seg_o`=0, `dp_o`=0 throughout.
- `brightness_i`=0xF, strobe with `digit_i`=6 at edge E -> `seg_o`=0x7D from E+1 onward; with `DP_HOLD`=8 for the test, `dp_o`=1 for exactly 8 cycles.
- `brightness_i`=4, digit 1 held -> over any 16 consecutive cycles `seg_o`=0x06 on exactly 4 cycles and 0 on 12; `brightness_i`=0 -> 0 lit cycles.
- Strobes for digits 2 then 3, 5 cycles apart, with `DP_HOLD`=8 -> `seg_o` 0x5B then 0x4F; `dp_o` stays high continuously for 13 cycles total.
- With `SEG7_BLINK_EN` and `BLINK_DIV`=3, `blink_req_i`=1 -> `seg_o` alternates 8 cycles glyph / 8 cycles 0. Dropping `blink_req_i` during a dark half -> glyph returns on the 2nd edge after the drop.
- Assert `rst_n`=0 for one cycle during a DP flash and a dark blink half -> the next cycle gives `seg_o`=0 and `dp_o`=0, and the state is BLANK until a new strobe.
